// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM state codes, reset-cause codes,
// counter width and the zero-as-one parameter helper.
package reset_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_POR        = 2'd0,
    S_ASSERT     = 2'd1,
    S_REL_PERIPH = 2'd2,
    S_RUN        = 2'd3
  } state_e;

  localparam logic [1:0] ST_POR        = S_POR;
  localparam logic [1:0] ST_ASSERT     = S_ASSERT;
  localparam logic [1:0] ST_REL_PERIPH = S_REL_PERIPH;
  localparam logic [1:0] ST_RUN        = S_RUN;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  // A cycle-count parameter of 0 is treated as 1.
  function automatic int eff_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request inputs and reset/status outputs of the reset sequencer, bundled with
// master (request source) and slave (sequencer) views.
interface reset_sequencer_if;

  logic       btn_n;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic       periph_resetn;
  logic       cpu_resetn;
  logic [1:0] cause;
  logic       busy;

  modport master (
    output btn_n, sw_rst_req, wdt_kick,
    input  periph_resetn, cpu_resetn, cause, busy
  );

  modport slave (
    input  btn_n, sw_rst_req, wdt_kick,
    output periph_resetn, cpu_resetn, cause, busy
  );

endinterface

// File: rtl/rst_debounce.sv
// Two-flop synchronizer plus debouncer for the raw active-low reset button;
// the output only follows the input after DEBOUNCE_CYCLES stable samples.
module rst_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic stable_n
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(eff_cycles(DEBOUNCE_CYCLES) - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  // cnt tracks consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      stable_n <= 1'b1;
    end else if (sync_b == stable_n) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt      <= '0;
      stable_n <= sync_b;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds peripheral and CPU resets after any request, then
// releases peripherals first and the CPU a gap later. Optional watchdog: RESET_SEQ_WDT_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 8,
  parameter int GAP_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WDT_CYCLES      = 1000
) (
  input  logic              clk,
  input  logic              resetn,
  reset_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(eff_cycles(HOLD_CYCLES) - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(eff_cycles(GAP_CYCLES) - 1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             db_n;
  logic             req_btn;
  logic             req_sw;
  logic             req_wdt;
  logic             req_any;
  logic [1:0]       req_cause;
  logic             periph_q;
  logic             cpu_q;
  logic [1:0]       cause_q;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk      (clk),
    .resetn   (resetn),
    .btn_n    (bus.btn_n),
    .stable_n (db_n)
  );

`ifdef RESET_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(eff_cycles(WDT_CYCLES) - 1);

  logic [CNT_W-1:0] wdt_cnt;

  // A kick on the expiry cycle wins, so a serviced watchdog never fires
  assign req_wdt = (state == ST_RUN) && (wdt_cnt == WDT_LAST) && !bus.wdt_kick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdt_cnt <= '0;
    end else if ((state != ST_RUN) || bus.wdt_kick || req_wdt) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = bus.wdt_kick ^ (WDT_CYCLES != 0);
  assign req_wdt    = 1'b0;
`endif

  always_comb begin
    req_btn   = !db_n;
    req_sw    = bus.sw_rst_req;
    req_any   = req_btn | req_wdt | req_sw;
    req_cause = req_btn ? CAUSE_BTN : (req_wdt ? CAUSE_WDT : CAUSE_SW);

    state_nx = state;
    if (req_any) begin
      state_nx = ST_ASSERT;
    end else begin
      case (state)
        ST_POR:        state_nx = ST_ASSERT;
        ST_ASSERT:     if (hold_cnt == HOLD_LAST) state_nx = ST_REL_PERIPH;
        ST_REL_PERIPH: if (gap_cnt == GAP_LAST) state_nx = ST_RUN;
        default:       state_nx = state;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state flop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_POR;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      cause_q  <= CAUSE_POR;
    end else begin
      state    <= state_nx;
      hold_cnt <= (state == ST_ASSERT && state_nx == ST_ASSERT && !req_any)
                  ? hold_cnt + CNT_W'(1) : '0;
      gap_cnt  <= (state == ST_REL_PERIPH && state_nx == ST_REL_PERIPH)
                  ? gap_cnt + CNT_W'(1) : '0;
      periph_q <= (state_nx == ST_REL_PERIPH) || (state_nx == ST_RUN);
      cpu_q    <= (state_nx == ST_RUN);
      if (req_any) cause_q <= req_cause;
    end
  end

  assign bus.periph_resetn = periph_q;
  assign bus.cpu_resetn    = cpu_q;
  assign bus.cause         = cause_q;
  assign bus.busy          = (state != ST_RUN);

endmodule
